// File: rtl/axis_red_pitaya_adc_capture_if.sv
// axis_red_pitaya_adc_capture_if: AXI-Stream bundle (tvalid/tready/tdata/tlast) for the ADC capture output.
interface axis_red_pitaya_adc_capture_if #(
   parameter int W = 32
);
   logic         tvalid;
   logic         tready;
   logic [W-1:0] tdata;
   logic         tlast;
   modport master(output tvalid, tdata, tlast, input tready);
   modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_red_pitaya_adc_capture.sv
// axis_red_pitaya_adc_capture: triggered ADC capture with offset-binary conversion, FWFT FIFO and AXIS output.
module axis_red_pitaya_adc_capture #(
   parameter int ADC_DATA_WIDTH   = 14,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH       = 16,
   parameter int CNT_WIDTH        = 32
) (
   input  logic                      aclk,
   input  logic                      areset,
   output logic                      adc_csn,
   input  logic [ADC_DATA_WIDTH-1:0] adc_dat_a,
   input  logic [ADC_DATA_WIDTH-1:0] adc_dat_b,
   input  logic [1:0]                cfg_mode,
   input  logic                      cfg_invert,
   input  logic [CNT_WIDTH-1:0]      cfg_length,
   input  logic                      trig,
   axis_red_pitaya_adc_capture_if.master m_axis,
   output logic                      sts_busy,
   output logic                      sts_overflow,
   output logic [CNT_WIDTH-1:0]      sts_count
);
   localparam int H  = AXIS_TDATA_WIDTH / 2;
   localparam int AW = $clog2(FIFO_DEPTH);

   if (H <= ADC_DATA_WIDTH) begin : g_bad_width
      $error("AXIS_TDATA_WIDTH/2 must exceed ADC_DATA_WIDTH");
   end
   if (FIFO_DEPTH < 4 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 4");
   end

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t                      state_q;
   logic [ADC_DATA_WIDTH-1:0]   a_q, b_q;
   logic [AXIS_TDATA_WIDTH-1:0] fmt_q, fmt_d, word_d;
   logic [1:0]                  mode_q, mode_e;
   logic                        inv_q, inv_e, ovf_q;
   logic [CNT_WIDTH-1:0]        len_q, cnt_q;
   logic [AW:0]                 wp_q, rp_q;
   logic [AXIS_TDATA_WIDTH:0]   mem_q [FIFO_DEPTH];
   logic [AXIS_TDATA_WIDTH:0]   head;
   logic [H-1:0]                ca, cb;
   logic                        empty, full, push, pop, last_d;

   function automatic logic [H-1:0] conv(input logic [ADC_DATA_WIDTH-1:0] x, input logic inv);
      logic [H-1:0] s;
      s = {{(H - ADC_DATA_WIDTH + 1){~x[ADC_DATA_WIDTH-1]}}, x[ADC_DATA_WIDTH-2:0]};
      return inv ? -s : s;
   endfunction

   // The format stage runs ahead of the trigger, so in IDLE it follows live config.
   assign mode_e = state_q == IDLE ? cfg_mode : mode_q;
   assign inv_e  = state_q == IDLE ? cfg_invert : inv_q;
   assign ca     = conv(a_q, inv_e);
   assign cb     = conv(b_q, inv_e);
   assign fmt_d  = mode_e == 2'b00 ? {cb, ca} :
                   mode_e == 2'b01 ? {{H{1'b0}}, ca} :
                   mode_e == 2'b10 ? {{H{1'b0}}, cb} : '0;
   assign word_d = mode_q == 2'b11 ? {{H{1'b0}}, cnt_q[H-1:0]} : fmt_q;
   assign last_d = cnt_q == len_q - 1'b1;

   assign empty  = wp_q == rp_q;
   assign full   = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
   assign pop    = m_axis.tvalid && m_axis.tready;
   assign push   = state_q == CAPTURE && (!full || pop);
   assign head   = mem_q[rp_q[AW-1:0]];

   assign m_axis.tvalid = !empty;
   assign m_axis.tdata  = empty ? '0 : head[AXIS_TDATA_WIDTH-1:0];
   assign m_axis.tlast  = !empty && head[AXIS_TDATA_WIDTH];
   assign adc_csn       = 1'b1;
   assign sts_busy      = state_q != IDLE;
   assign sts_overflow  = ovf_q;
   assign sts_count     = cnt_q;

   always_ff @(posedge aclk) if (push) mem_q[wp_q[AW-1:0]] <= {last_d, word_d};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         fmt_q   <= '0;
         mode_q  <= '0;
         inv_q   <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         wp_q    <= '0;
         rp_q    <= '0;
      end else begin
         a_q   <= adc_dat_a;
         b_q   <= adc_dat_b;
         fmt_q <= fmt_d;
         if (push) wp_q <= wp_q + 1'b1;
         if (pop) rp_q <= rp_q + 1'b1;
         case (state_q)
            IDLE: if (trig && cfg_length != '0) begin
               state_q <= CAPTURE;
               mode_q  <= cfg_mode;
               inv_q   <= cfg_invert;
               len_q   <= cfg_length;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
            end
            CAPTURE: if (push) begin
               cnt_q <= cnt_q + 1'b1;
               if (last_d) state_q <= DRAIN;
            end else ovf_q <= 1'b1;
            DRAIN: if (pop && head[AXIS_TDATA_WIDTH]) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
